edge_track_win_ctrl: RTL and testbench
======================================

EDGE_TRACK_WIN_CTRL -- requirements
Module: edge_track_win_ctrl

Interface
REQ-001 Parameter: IMG_WIDTH, default 512, pixels per image line; legal range 4..4096.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 run  input  1  scheduler enable; window reads start only while high.
REQ-005 pixel_in  input  8  thresholded pixel (0, 255 or intermediate), raster order.
REQ-006 pixel_in_valid  input  1  pixel_in qualifier, one pixel per cycle max.
REQ-007 window_out  output  72  3x3 window for edge_track data_in.
REQ-008 window_out_valid  output  1  window_out qualifier, maps to edge_track data_in_valid.
REQ-009 line_req  output  1  one-cycle pulse: one line buffer freed, upstream may send another line.
REQ-010 overflow  output  1  sticky flag: a valid pixel arrived while all buffers full.

Function
REQ-011 Storage SHALL be 4 line buffers of IMG_WIDTH x 8 bits; write line index wl (0..3), write column wc (0..IMG_WIDTH-1).
REQ-012 Accepted pixel (valid and count < 4*IMG_WIDTH) SHALL be written to buffer wl, column wc; wc increments, wraps to 0 at IMG_WIDTH-1 with wl incrementing mod 4.
REQ-013 count (width clog2(4*IMG_WIDTH+1)) SHALL track stored unread pixels: +1 per accepted pixel, -IMG_WIDTH in DONE, both applied same cycle when simultaneous.
REQ-014 Pixel with pixel_in_valid while count == 4*IMG_WIDTH SHALL be dropped, no pointer/count change, overflow set to 1 until reset.
REQ-015 FSM states: IDLE, READ, DONE.
REQ-016 IDLE -> READ when run == 1 and count >= 3*IMG_WIDTH; column counter rc cleared to 0; otherwise remain IDLE.
REQ-017 READ: each cycle fetch columns rc, rc+1, rc+2 of buffers rl, rl+1, rl+2 (mod 4); rc increments; READ -> DONE when rc == IMG_WIDTH-3; run deassertion mid-READ SHALL NOT abort the line.
REQ-018 DONE: one cycle; rl increments mod 4; count decremented per REQ-013; line_req = 1; -> IDLE.
REQ-019 line_req SHALL be 1 exactly in DONE cycles, 0 otherwise.
REQ-020 window_out/window_out_valid SHALL be registered: fetch in READ cycle n appears in cycle n+1; window_out_valid = 1 for exactly IMG_WIDTH-2 consecutive cycles per line.
REQ-021 Packing: row k (0 = line rl, 2 = line rl+2) occupies bits [24k+23:24k]; column rc at [24k+23:24k+16], rc+1 at [24k+15:24k+8], rc+2 at [24k+7:24k].
REQ-022 window_out SHALL hold last value when window_out_valid = 0.
REQ-023 No border padding: first/last image column produce no centred window; edge windows excluded.
REQ-024 Writes into buffer rl+3 during READ SHALL be allowed; writes into rl..rl+2 cannot occur (count bound).

Reset
REQ-025 On rst: state IDLE, wl, wc, rl, rc, count = 0; window_out = 0, window_out_valid = 0, line_req = 0, overflow = 0.
REQ-026 Reset mid-READ SHALL abandon the line, discard all buffered data, no line_req emitted.
REQ-027 Buffer contents need not be cleared; unread data is invalid via count = 0.

Verification (IMG_WIDTH = 8)
REQ-028 Assert rst 2 cycles, pixel_in_valid = 1 -> all outputs 0, count 0, no write.
REQ-029 run = 1, stream pixels 0..23 -> READ entered cycle after 24th write; 6 valid windows, first = {16,17,18, 8,9,10, 0,1,2} (bits 71..0), last = {21,22,23, 13,14,15, 5,6,7}; then line_req one cycle.
REQ-030 run = 0, send 33 pixels -> 32 stored, overflow = 1, no window_out_valid, no line_req.
REQ-031 From REQ-030, set run = 1 -> 6 windows from lines 0-2, line_req, count 24, immediate second READ of lines 1-3 (first window top row 8,9,10).
REQ-032 Continuous input during READ at count 24 -> count after DONE = 24 - 8 + pixels accepted, no pixel lost, overflow 0.
REQ-033 rst at 3rd window_out_valid cycle -> window_out_valid 0 next cycle, no line_req, new 24-pixel stream reproduces REQ-029.

Source files
------------

// File: rtl/edge_track_win_ctrl.sv
// Line-buffer scheduler feeding edge_track: stores raster pixels in four line buffers and,
// once three full lines are held, emits the centred 3x3 windows of the oldest line triple.
module edge_track_win_ctrl #(
  parameter int unsigned IMG_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic [71:0] window_out,
  output logic        window_out_valid,
  output logic        line_req,
  output logic        overflow
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned NW = $clog2(4 * IMG_WIDTH + 1);

  localparam logic [NW-1:0] FullCount  = NW'(4 * IMG_WIDTH);
  localparam logic [NW-1:0] ThreeLines = NW'(3 * IMG_WIDTH);
  localparam logic [NW-1:0] OneLine    = NW'(IMG_WIDTH);
  localparam logic [CW-1:0] LastWrCol  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LastRdCol  = CW'(IMG_WIDTH - 3);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  logic [7:0]    r_mem [4][IMG_WIDTH];
  state_e        r_state, w_state_nxt;
  logic [1:0]    r_wl, r_rl, w_rl_nxt;
  logic [CW-1:0] r_wc, r_rc, w_rc_nxt;
  logic [NW-1:0] r_count, w_count_nxt;
  logic          w_accept, w_drop, w_fetch, w_release;
  logic [CW-1:0] w_c1, w_c2;
  logic [71:0]   w_win;

  assign w_accept = pixel_in_valid && (r_count != FullCount);
  assign w_drop   = pixel_in_valid && (r_count == FullCount);
  assign w_c1     = r_rc + CW'(1);
  assign w_c2     = r_rc + CW'(2);
  assign line_req = (r_state == StDone);

  function automatic logic [23:0] row(input logic [1:0] l);
    return {r_mem[l][r_rc], r_mem[l][w_c1], r_mem[l][w_c2]};
  endfunction

  // Row 0 is the oldest line and sits in the low bits of the window.
  assign w_win = {row(r_rl + 2'd2), row(r_rl + 2'd1), row(r_rl)};

  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    w_rl_nxt    = r_rl;
    w_fetch     = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (run && (r_count >= ThreeLines)) begin
          w_state_nxt = StRead;
          w_rc_nxt    = '0;
        end
      end
      StRead: begin
        // A started line always completes, independent of run.
        w_fetch  = 1'b1;
        w_rc_nxt = r_rc + CW'(1);
        if (r_rc == LastRdCol) w_state_nxt = StDone;
      end
      StDone: begin
        w_release   = 1'b1;
        w_rl_nxt    = r_rl + 2'd1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept)  w_count_nxt = w_count_nxt + NW'(1);
    if (w_release) w_count_nxt = w_count_nxt - OneLine;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= StIdle;
      r_wl             <= '0;
      r_wc             <= '0;
      r_rl             <= '0;
      r_rc             <= '0;
      r_count          <= '0;
      window_out       <= '0;
      window_out_valid <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_rl             <= w_rl_nxt;
      r_rc             <= w_rc_nxt;
      r_count          <= w_count_nxt;
      window_out_valid <= w_fetch;
      if (w_fetch) window_out <= w_win;
      if (w_drop)  overflow   <= 1'b1;
      if (w_accept) begin
        if (r_wc == LastWrCol) begin
          r_wc <= '0;
          r_wl <= r_wl + 2'd1;
        end else begin
          r_wc <= r_wc + CW'(1);
        end
      end
    end
  end

  // Storage is not cleared on reset; count == 0 marks all of it as stale.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_mem[r_wl][r_wc] <= pixel_in;
  end

endmodule

// File: tb/tb_edge_track_win_ctrl.sv
// Directed bench for edge_track_win_ctrl with IMG_WIDTH = 8; expected windows are built
// from the raster value of each pixel (line * 8 + column).
module tb_edge_track_win_ctrl;

  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic        pixel_in_valid = 1'b0;
  logic [71:0] window_out;
  logic        window_out_valid;
  logic        line_req;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_cyc = -1;
  int n_lr = 0;
  int cyc24;
  logic [71:0] wins[$];

  edge_track_win_ctrl #(.IMG_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .pixel_in         (pixel_in),
    .pixel_in_valid   (pixel_in_valid),
    .window_out       (window_out),
    .window_out_valid (window_out_valid),
    .line_req         (line_req),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (window_out_valid) begin
      if (wins.size() == 0) first_cyc = cyc;
      wins.push_back(window_out);
    end
    if (line_req) n_lr++;
  endtask

  task automatic clear_log();
    wins.delete();
    n_lr = 0;
    first_cyc = -1;
  endtask

  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      pixel_in = 8'(first + i);
      pixel_in_valid = 1'b1;
      tick();
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Window for oldest line l (absolute raster line) at left column c.
  function automatic logic [71:0] ew(input int l, input int c);
    logic [71:0] r;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        r[24*k + 8*(2-j) +: 8] = 8'((l + k) * 8 + c + j);
    return r;
  endfunction

  function automatic logic [71:0] qat(input int i);
    if (i < wins.size()) return wins[i];
    return 'x;
  endfunction

  task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a valid pixel presented: nothing may be stored.
    pixel_in = 8'hAA;
    pixel_in_valid = 1'b1;
    tick();
    tick();
    chk72("rst_window", window_out, 72'h0);
    chki("rst_valid", int'(window_out_valid), 0);
    chki("rst_line_req", int'(line_req), 0);
    chki("rst_overflow", int'(overflow), 0);
    chki("rst_count", int'(dut.r_count), 0);
    pixel_in_valid = 1'b0;
    rst = 1'b0;

    // One full triple of lines.
    run = 1'b1;
    clear_log();
    stream(0, 24);
    cyc24 = cyc;
    repeat (12) tick();
    chki("l1_first_latency", first_cyc, cyc24 + 2);
    chki("l1_nwin", wins.size(), 6);
    chk72("l1_first", qat(0), ew(0, 0));
    chk72("l1_last", qat(5), ew(0, 5));
    chki("l1_line_req", n_lr, 1);
    chk72("l1_hold", window_out, ew(0, 5));
    chki("l1_count", int'(dut.r_count), 16);

    // Fill all four buffers with run low; 33rd pixel is dropped.
    do_reset();
    run = 1'b0;
    clear_log();
    stream(0, 33);
    repeat (3) tick();
    chki("ov_flag", int'(overflow), 1);
    chki("ov_count", int'(dut.r_count), 32);
    chki("ov_nwin", wins.size(), 0);
    chki("ov_line_req", n_lr, 0);

    // Enabling run drains two line triples back to back.
    run = 1'b1;
    clear_log();
    repeat (30) tick();
    chki("dr_nwin", wins.size(), 12);
    chk72("dr_a_first", qat(0), ew(0, 0));
    chk72("dr_b_first", qat(6), ew(1, 0));
    chk72("dr_b_last", qat(11), ew(1, 5));
    chki("dr_line_req", n_lr, 2);
    chki("dr_count", int'(dut.r_count), 16);
    chki("dr_ov_sticky", int'(overflow), 1);

    // Continuous input while reading: pixels written into the free buffer survive.
    do_reset();
    run = 1'b1;
    clear_log();
    stream(0, 34);
    repeat (20) tick();
    chki("ct_nwin", wins.size(), 12);
    chk72("ct_a_first", qat(0), ew(0, 0));
    chk72("ct_a_last", qat(5), ew(0, 5));
    chk72("ct_b_first", qat(6), ew(1, 0));
    chk72("ct_b_last", qat(11), ew(1, 5));
    chki("ct_line_req", n_lr, 2);
    chki("ct_count", int'(dut.r_count), 18);
    chki("ct_overflow", int'(overflow), 0);

    // Reset in the middle of a line.
    do_reset();
    clear_log();
    stream(0, 24);
    for (int i = 0; i < 20; i++) begin
      if (wins.size() == 3) break;
      tick();
    end
    chki("mr_reached3", wins.size(), 3);
    rst = 1'b1;
    tick();
    chki("mr_valid", int'(window_out_valid), 0);
    chki("mr_line_req", int'(line_req), 0);
    rst = 1'b0;
    clear_log();
    repeat (10) tick();
    chki("mr_quiet_nwin", wins.size(), 0);
    chki("mr_quiet_lr", n_lr, 0);
    clear_log();
    stream(0, 24);
    cyc24 = cyc;
    repeat (12) tick();
    chki("mr_latency", first_cyc, cyc24 + 2);
    chki("mr_nwin", wins.size(), 6);
    chk72("mr_first", qat(0), ew(0, 0));
    chk72("mr_last", qat(5), ew(0, 5));
    chki("mr_line_req", n_lr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
